// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: READ (0x03), JEDEC ID (0x9F), STATUS (0x05) over a byte memory port.
// Define SPI_FLASH_RESPONDER_FAST_READ_EN to add FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter logic [7:0]  STATUS_BYTE = 8'h00
) (
    input  logic        clk_48mhz,
    input  logic        reset,
    input  logic        spi_cs,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [23:0] mem_addr,
    output logic        mem_rd_req,
    input  logic        mem_rd_ack,
    input  logic [7:0]  mem_rd_data,
    output logic        err_underrun
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
        S_DUMMY,
`endif
        S_DATA,
        S_IGNORE
    } state_t;

    typedef enum logic [1:0] {M_ID, M_STATUS, M_READ} mode_t;

    state_t      r_state;
    mode_t       r_mode;
    logic [1:0]  r_cs_s;
    logic [1:0]  r_sck_s;
    logic [1:0]  r_mosi_s;
    logic        r_sck_d;
    logic [4:0]  r_cnt;
    logic [22:0] r_sh;
    logic [7:0]  r_tx;
    logic [1:0]  r_idx;
    logic [7:0]  r_pf;
    logic        r_pf_vld;
    logic        r_late;
    logic        r_miso;
    logic [23:0] r_addr;
    logic        r_req;
    logic        r_err;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    logic        r_fast;
`endif

    logic        w_cs;
    logic        w_mosi;
    logic        w_rise;
    logic        w_fall;
    logic        w_ack;
    logic        w_pf_avail;
    logic [7:0]  w_pf_byte;
    logic [7:0]  w_cmd;
    logic [23:0] w_addr;
    logic [7:0]  w_byte;

    assign w_cs       = r_cs_s[1];
    assign w_mosi     = r_mosi_s[1];
    assign w_rise     = r_sck_s[1] & ~r_sck_d;
    assign w_fall     = ~r_sck_s[1] & r_sck_d;
    assign w_ack      = mem_rd_ack & r_req;
    assign w_cmd      = {r_sh[6:0], w_mosi};
    assign w_addr     = {r_sh, w_mosi};
    // An ack landing on the boundary cycle still feeds that byte.
    assign w_pf_avail = r_pf_vld | (w_ack & ~r_late);
    assign w_pf_byte  = r_pf_vld ? r_pf : mem_rd_data;

    always_comb begin
        w_byte = 8'h00;
        case (r_mode)
            M_ID: begin
                case (r_idx)
                    2'd0:    w_byte = JEDEC_ID[23:16];
                    2'd1:    w_byte = JEDEC_ID[15:8];
                    2'd2:    w_byte = JEDEC_ID[7:0];
                    default: w_byte = 8'h00;
                endcase
            end
            M_STATUS: w_byte = STATUS_BYTE;
            default:  w_byte = w_pf_avail ? w_pf_byte : 8'hFF;
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mode   <= M_ID;
            r_cs_s   <= 2'b11;
            r_sck_s  <= 2'b00;
            r_mosi_s <= 2'b00;
            r_sck_d  <= 1'b0;
            r_cnt    <= 5'd0;
            r_sh     <= 23'd0;
            r_tx     <= 8'h00;
            r_idx    <= 2'd0;
            r_pf     <= 8'h00;
            r_pf_vld <= 1'b0;
            r_late   <= 1'b0;
            r_miso   <= 1'b0;
            r_addr   <= 24'd0;
            r_req    <= 1'b0;
            r_err    <= 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
            r_fast   <= 1'b0;
`endif
        end else begin
            r_cs_s   <= {r_cs_s[0], spi_cs};
            r_sck_s  <= {r_sck_s[0], spi_sck};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_sck_d  <= r_sck_s[1];
            if (w_ack) begin
                r_req  <= 1'b0;
                r_addr <= r_addr + 24'd1;
                if (r_late) begin
                    r_late <= 1'b0;
                end else begin
                    r_pf     <= mem_rd_data;
                    r_pf_vld <= 1'b1;
                end
            end
            if (w_cs) begin
                r_state  <= S_IDLE;
                r_cnt    <= 5'd0;
                r_req    <= 1'b0;
                r_late   <= 1'b0;
                r_pf_vld <= 1'b0;
                r_miso   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_CMD;
                        r_cnt   <= 5'd0;
                    end
                    S_CMD: if (w_rise) begin
                        r_sh  <= {r_sh[21:0], w_mosi};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd7) begin
                            r_cnt <= 5'd0;
                            r_idx <= 2'd0;
                            case (w_cmd)
                                8'h03: begin
                                    r_state <= S_ADDR;
                                    r_mode  <= M_READ;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                                    r_fast  <= 1'b0;
                                end
                                8'h0B: begin
                                    r_state <= S_ADDR;
                                    r_mode  <= M_READ;
                                    r_fast  <= 1'b1;
`endif
                                end
                                8'h9F: begin
                                    r_state <= S_DATA;
                                    r_mode  <= M_ID;
                                end
                                8'h05: begin
                                    r_state <= S_DATA;
                                    r_mode  <= M_STATUS;
                                end
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (w_rise) begin
                        r_sh  <= {r_sh[21:0], w_mosi};
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd23) begin
                            r_cnt  <= 5'd0;
                            r_addr <= w_addr;
                            r_req  <= 1'b1;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                            r_state <= r_fast ? S_DUMMY : S_DATA;
`else
                            r_state <= S_DATA;
`endif
                        end
                    end
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
                    S_DUMMY: if (w_rise) begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd7) begin
                            r_cnt   <= 5'd0;
                            r_state <= S_DATA;
                        end
                    end
`endif
                    S_DATA: begin
                        if (w_rise)
                            r_cnt <= {2'b00, r_cnt[2:0] + 3'd1};
                        if (w_fall && r_cnt[2:0] == 3'd0) begin
                            r_miso <= w_byte[7];
                            r_tx   <= {w_byte[6:0], 1'b0};
                            if (r_idx != 2'd3)
                                r_idx <= r_idx + 2'd1;
                            if (r_mode == M_READ) begin
                                if (w_pf_avail) begin
                                    r_pf_vld <= 1'b0;
                                    r_req    <= 1'b1;
                                end else begin
                                    r_err <= 1'b1;
                                    if (r_req)
                                        r_late <= 1'b1;
                                    else
                                        r_req <= 1'b1;
                                end
                            end
                        end else if (w_fall) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    S_IGNORE: r_miso <= 1'b0;
                    default:  r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_miso     = r_miso;
    assign mem_addr     = r_addr;
    assign mem_rd_req   = r_req;
    assign err_underrun = r_err;
endmodule
